// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: handshake, execute-status and pipeline-control bundle between
// the run-mode sequencer (slave side) and the host/loader/pipeline side (master).
interface pipe_ctrl_if #(
    parameter int NSTAGE = 3,
    parameter int LAT_W  = 5
);
    // host / loader handshake
    logic                  host_start;
    logic                  load_done;
    logic                  load_ack;
    // execute-stage status
    logic [LAT_W-1:0]      ex_wait;
    logic                  ex_busy;
    logic                  hazard;
    logic                  flush;
    logic                  stop_req;
    // sequencer outputs
    logic [1:0]            mode;
    logic [2*NSTAGE-1:0]   upd;
    logic                  ex_done;
    logic                  ex_start;
    logic [LAT_W-1:0]      lat_cnt;
    logic [31:0]           cyc_cnt;
    logic [31:0]           stall_cnt;
    logic [31:0]           bubble_cnt;
    logic [31:0]           flush_cnt;

    modport master (
        output host_start, load_done, load_ack,
        output ex_wait, ex_busy, hazard, flush, stop_req,
        input  mode, upd, ex_done, ex_start, lat_cnt,
        input  cyc_cnt, stall_cnt, bubble_cnt, flush_cnt
    );

    modport slave (
        input  host_start, load_done, load_ack,
        input  ex_wait, ex_busy, hazard, flush, stop_req,
        output mode, upd, ex_done, ex_start, lat_cnt,
        output cyc_cnt, stall_cnt, bubble_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: run-mode sequencer (STALL/LOAD/EXEC/STOP) for an NSTAGE-deep
// register pipeline. Owns the execute latency counter, the per-boundary
// hold/advance/clear codes, taken-branch flush, hazard bubble insertion at
// boundary HAZ_STAGE and restart from STOP.
// Optional build macro: PIPE_PERF_EN enables the 32-bit performance counters;
// without it the counter outputs are tied to zero.
module pipe_ctrl #(
    parameter int NSTAGE    = 3,
    parameter int LAT_W     = 5,
    parameter int HAZ_STAGE = 1
) (
    input  logic          clk,
    input  logic          rst,
    pipe_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_STALL = 2'd0,
        ST_LOAD  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_STOP  = 2'd3
    } mode_e;

    localparam logic [1:0] UPD_HOLD  = 2'b00;
    localparam logic [1:0] UPD_ADV   = 2'b01;
    localparam logic [1:0] UPD_CLEAR = 2'b10;

    mode_e              mode_q;
    mode_e              mode_d;
    logic [LAT_W-1:0]   lat_cnt_q;
    logic [LAT_W-1:0]   lat_cnt_d;
    logic               ex_start_q;
    logic               ex_start_d;
    logic               ex_done_s;
    logic [2*NSTAGE-1:0] upd_s;

    // Execute completes once the latency count has reached the requested wait
    // and the external unit is not holding us off.
    always_comb begin
        ex_done_s = 1'b0;
        if (mode_q == ST_EXEC) begin
            ex_done_s = (lat_cnt_q >= bus.ex_wait) && !bus.ex_busy;
        end else begin
            ex_done_s = 1'b0;
        end
    end

    // Next-state, latency counter and start pulse for the run-mode FSM.
    always_comb begin
        mode_d     = mode_q;
        lat_cnt_d  = {LAT_W{1'b0}};
        ex_start_d = 1'b0;
        case (mode_q)
            ST_STALL: begin
                if (bus.host_start) begin
                    mode_d = ST_LOAD;
                end else begin
                    mode_d = ST_STALL;
                end
            end
            ST_LOAD: begin
                if (bus.load_done && bus.load_ack) begin
                    mode_d     = ST_EXEC;
                    ex_start_d = 1'b1;
                end else begin
                    mode_d     = ST_LOAD;
                    ex_start_d = 1'b0;
                end
            end
            ST_EXEC: begin
                // Count only up to ex_wait; beyond that we are waiting on ex_busy.
                if (ex_done_s) begin
                    lat_cnt_d = {LAT_W{1'b0}};
                end else if (lat_cnt_q < bus.ex_wait) begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end else begin
                    lat_cnt_d = lat_cnt_q;
                end
                if (bus.stop_req && ex_done_s) begin
                    mode_d     = ST_STOP;
                    ex_start_d = 1'b0;
                end else begin
                    mode_d     = ST_EXEC;
                    ex_start_d = ex_done_s;
                end
            end
            ST_STOP: begin
                if (bus.host_start) begin
                    mode_d = ST_STALL;
                end else begin
                    mode_d = ST_STOP;
                end
            end
            default: begin
                mode_d = ST_STALL;
            end
        endcase
    end

    // Per-boundary pipeline register codes; flush takes priority over hazard.
    always_comb begin
        upd_s = {(2*NSTAGE){1'b0}};
        case (mode_q)
            ST_STALL, ST_LOAD: begin
                for (int i = 0; i < NSTAGE; i++) begin
                    upd_s[2*i +: 2] = UPD_CLEAR;
                end
            end
            ST_EXEC: begin
                for (int i = 0; i < NSTAGE; i++) begin
                    if (!ex_done_s) begin
                        upd_s[2*i +: 2] = UPD_HOLD;
                    end else if (bus.flush) begin
                        upd_s[2*i +: 2] = (i <= HAZ_STAGE) ? UPD_CLEAR : UPD_ADV;
                    end else if (bus.hazard) begin
                        if (i < HAZ_STAGE) begin
                            upd_s[2*i +: 2] = UPD_HOLD;
                        end else if (i == HAZ_STAGE) begin
                            upd_s[2*i +: 2] = UPD_CLEAR;
                        end else begin
                            upd_s[2*i +: 2] = UPD_ADV;
                        end
                    end else begin
                        upd_s[2*i +: 2] = UPD_ADV;
                    end
                end
            end
            ST_STOP: begin
                for (int i = 0; i < NSTAGE; i++) begin
                    upd_s[2*i +: 2] = UPD_HOLD;
                end
            end
            default: begin
                for (int i = 0; i < NSTAGE; i++) begin
                    upd_s[2*i +: 2] = UPD_CLEAR;
                end
            end
        endcase
    end

    // State, latency counter and start-pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= ST_STALL;
            lat_cnt_q  <= {LAT_W{1'b0}};
            ex_start_q <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            lat_cnt_q  <= lat_cnt_d;
            ex_start_q <= ex_start_d;
        end
    end

    assign bus.mode     = mode_q;
    assign bus.lat_cnt  = lat_cnt_q;
    assign bus.ex_start = ex_start_q;
    assign bus.ex_done  = ex_done_s;
    assign bus.upd      = upd_s;

`ifdef PIPE_PERF_EN
    logic [31:0] cyc_cnt_q;
    logic [31:0] cyc_cnt_d;
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [31:0] bubble_cnt_q;
    logic [31:0] bubble_cnt_d;
    logic [31:0] flush_cnt_q;
    logic [31:0] flush_cnt_d;

    // Performance counters: restart on every new program load, wrap at 2^32.
    always_comb begin
        cyc_cnt_d    = cyc_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if ((mode_q == ST_STALL) && bus.host_start) begin
            cyc_cnt_d    = 32'd0;
            stall_cnt_d  = 32'd0;
            bubble_cnt_d = 32'd0;
            flush_cnt_d  = 32'd0;
        end else if (mode_q == ST_EXEC) begin
            cyc_cnt_d = cyc_cnt_q + 32'd1;
            if (!ex_done_s) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end else if (bus.flush) begin
                flush_cnt_d = flush_cnt_q + 32'd1;
            end else if (bus.hazard) begin
                bubble_cnt_d = bubble_cnt_q + 32'd1;
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
        end else begin
            cyc_cnt_d = cyc_cnt_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt_q    <= 32'd0;
            stall_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
            flush_cnt_q  <= 32'd0;
        end else begin
            cyc_cnt_q    <= cyc_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign bus.cyc_cnt    = cyc_cnt_q;
    assign bus.stall_cnt  = stall_cnt_q;
    assign bus.bubble_cnt = bubble_cnt_q;
    assign bus.flush_cnt  = flush_cnt_q;
`else
    assign bus.cyc_cnt    = 32'd0;
    assign bus.stall_cnt  = 32'd0;
    assign bus.bubble_cnt = 32'd0;
    assign bus.flush_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: table-driven check of pipe_ctrl (NSTAGE=3, LAT_W=5,
// HAZ_STAGE=1). Each table row is one clock cycle of inputs plus the outputs
// expected in that same cycle; expected rows go through a scoreboard queue.
module tb_pipe_ctrl;

    localparam int NSTAGE = 3;
    localparam int LAT_W  = 5;

    localparam logic [5:0] U10 = 6'b101010;  // all clear
    localparam logic [5:0] U00 = 6'b000000;  // all hold
    localparam logic [5:0] U01 = 6'b010101;  // all advance
    localparam logic [5:0] UHZ = 6'b011000;  // hazard bubble at boundary 1
    localparam logic [5:0] UFL = 6'b011010;  // flush boundaries 0..1

    typedef struct {
        logic       rst;
        logic       hs;
        logic       ld;
        logic       la;
        logic [4:0] w;
        logic       bz;
        logic       hz;
        logic       fl;
        logic       sr;
        logic [1:0] e_mode;
        logic [5:0] e_upd;
        logic       e_done;
        logic       e_start;
        logic [4:0] e_lat;
    } vec_t;

    logic clk;
    logic rst;
    int   n_run;
    int   n_fail;

    vec_t tbl[26];
    vec_t exp_q[$];

    pipe_ctrl_if #(.NSTAGE(NSTAGE), .LAT_W(LAT_W)) bus ();

    pipe_ctrl #(.NSTAGE(NSTAGE), .LAT_W(LAT_W), .HAZ_STAGE(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic hs, input logic ld,
                                input logic la, input logic [4:0] w, input logic bz,
                                input logic hz, input logic fl, input logic sr,
                                input logic [1:0] em, input logic [5:0] eu,
                                input logic ed, input logic es, input logic [4:0] el);
        vec_t v;
        v.rst = r;  v.hs = hs; v.ld = ld; v.la = la; v.w = w;
        v.bz = bz;  v.hz = hz; v.fl = fl; v.sr = sr;
        v.e_mode = em; v.e_upd = eu; v.e_done = ed; v.e_start = es; v.e_lat = el;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic hs, input logic ld, input logic la,
                         input logic [4:0] w, input logic bz, input logic hz,
                         input logic fl, input logic sr);
        rst = r;
        bus.host_start = hs; bus.load_done = ld; bus.load_ack = la;
        bus.ex_wait = w; bus.ex_busy = bz; bus.hazard = hz;
        bus.flush = fl; bus.stop_req = sr;
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] c, input logic [31:0] s,
                           input logic [31:0] b, input logic [31:0] f);
        chk({tag, ".cyc_cnt"},    bus.cyc_cnt,    c);
        chk({tag, ".stall_cnt"},  bus.stall_cnt,  s);
        chk({tag, ".bubble_cnt"}, bus.bubble_cnt, b);
        chk({tag, ".flush_cnt"},  bus.flush_cnt,  f);
    endtask

    // Watchdog: the bench must never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t cur;
        n_run  = 0;
        n_fail = 0;

        //        rst hs ld la  w  bz hz fl sr   mode upd  done start lat
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, U10, 0, 0, 0);  // reset state
        tbl[1]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0,  0, U10, 0, 0, 0);  // host_start
        tbl[2]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0,  1, U10, 0, 0, 0);  // load_done w/o ack holds
        tbl[3]  = mk(0, 0, 1, 1, 3, 0, 0, 0, 0,  1, U10, 0, 0, 0);  // load complete
        tbl[4]  = mk(0, 0, 0, 0, 3, 0, 0, 0, 0,  2, U00, 0, 1, 0);  // first EXEC, ex_start
        tbl[5]  = mk(0, 0, 0, 0, 3, 0, 0, 0, 0,  2, U00, 0, 0, 1);
        tbl[6]  = mk(0, 0, 0, 0, 3, 0, 0, 0, 0,  2, U00, 0, 0, 2);
        tbl[7]  = mk(0, 0, 0, 0, 3, 0, 0, 0, 0,  2, U01, 1, 0, 3);  // done in 4th cycle
        tbl[8]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0,  2, U00, 0, 1, 0);  // busy stretch
        tbl[9]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0,  2, U00, 0, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  2, U01, 1, 0, 0);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0,  2, UHZ, 1, 1, 0);  // hazard bubble
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0,  2, UFL, 1, 1, 0);  // flush beats hazard
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0,  2, UFL, 1, 1, 0);  // flush alone
        tbl[14] = mk(0, 0, 0, 0, 2, 0, 0, 1, 0,  2, U00, 0, 1, 0);  // flush ignored w/o done
        tbl[15] = mk(0, 0, 0, 0, 2, 0, 0, 0, 1,  2, U00, 0, 0, 1);  // stop_req w/o done
        tbl[16] = mk(0, 0, 0, 0, 2, 0, 1, 0, 1,  2, UHZ, 1, 0, 2);  // stop with hazard
        tbl[17] = mk(0, 0, 1, 1, 2, 0, 1, 1, 0,  3, U00, 0, 0, 0);  // STOP freezes
        tbl[18] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0,  3, U00, 0, 0, 0);  // restart
        tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, U10, 0, 0, 0);
        tbl[20] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0,  0, U10, 0, 0, 0);
        tbl[21] = mk(0, 0, 1, 1, 0, 0, 0, 0, 0,  1, U10, 0, 0, 0);
        tbl[22] = mk(0, 0, 0, 0, 5, 0, 0, 0, 0,  2, U00, 0, 1, 0);
        tbl[23] = mk(0, 0, 0, 0, 5, 0, 0, 0, 0,  2, U00, 0, 0, 1);
        tbl[24] = mk(1, 0, 0, 0, 5, 0, 0, 0, 0,  2, U00, 0, 0, 2);  // rst mid-wait
        tbl[25] = mk(0, 0, 0, 0, 5, 0, 0, 0, 0,  0, U10, 0, 0, 0);

        // Initial reset: two edges with rst high before the table starts.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        for (int i = 0; i < 26; i++) begin
            if (i != 0) @(negedge clk);
            drive(tbl[i].rst, tbl[i].hs, tbl[i].ld, tbl[i].la, tbl[i].w,
                  tbl[i].bz, tbl[i].hz, tbl[i].fl, tbl[i].sr);
            exp_q.push_back(tbl[i]);
            #1;
            cur = exp_q.pop_front();
            chk($sformatf("row%0d.mode", i),     {30'd0, bus.mode},     {30'd0, cur.e_mode});
            chk($sformatf("row%0d.upd", i),      {26'd0, bus.upd},      {26'd0, cur.e_upd});
            chk($sformatf("row%0d.ex_done", i),  {31'd0, bus.ex_done},  {31'd0, cur.e_done});
            chk($sformatf("row%0d.ex_start", i), {31'd0, bus.ex_start}, {31'd0, cur.e_start});
            chk($sformatf("row%0d.lat_cnt", i),  {27'd0, bus.lat_cnt},  {27'd0, cur.e_lat});
        end

        // Counters are zero after the mid-operation reset.
        chk_cnt("post_rst", 32'd0, 32'd0, 32'd0, 32'd0);

        // Performance run: load, then 10 EXEC cycles (2 busy, 1 hazard, 1 flush),
        // ending with stop_req on the last completing cycle.
        @(negedge clk); drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); drive(1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0,
                  (c == 2 || c == 5), (c == 3), (c == 7), (c == 9));
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("perf.mode_stop", {30'd0, bus.mode}, 32'd3);
        chk("perf.upd_stop",  {26'd0, bus.upd},  {26'd0, U00});
`ifdef PIPE_PERF_EN
        chk_cnt("perf", 32'd10, 32'd2, 32'd1, 32'd1);
`else
        chk_cnt("perf", 32'd0, 32'd0, 32'd0, 32'd0);
`endif
        // STOP -> STALL keeps counters; STALL -> LOAD clears them.
        @(negedge clk); drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("keep.mode_stall", {30'd0, bus.mode}, 32'd0);
`ifdef PIPE_PERF_EN
        chk_cnt("keep", 32'd10, 32'd2, 32'd1, 32'd1);
`else
        chk_cnt("keep", 32'd0, 32'd0, 32'd0, 32'd0);
`endif
        @(negedge clk); drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("clr.mode_load", {30'd0, bus.mode}, 32'd1);
        chk_cnt("clr", 32'd0, 32'd0, 32'd0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
